// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: reset/bubble constants, fetch FSM states
// and the IF/ID pipeline record.
package pipe_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        predicted;
      logic        valid;
   } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Stall/flush pipeline register for an if_id_t record. Flush beats stall;
// a flushed slot keeps the incoming pc but carries the bubble instruction.
module if_id_reg
   import pipe_pkg::*;
#(
   parameter logic [31:0] BUBBLE_INSTR = pipe_pkg::NOP_INSTR
) (
   input  logic   i_clk,
   input  logic   i_rst,
   input  logic   i_flush,
   input  logic   i_stall,
   input  if_id_t i_d,
   output if_id_t o_q
);

   if_id_t reg_q;
   if_id_t reg_d;

   always_comb begin
      reg_d = reg_q;
      if (i_flush) begin
         reg_d.pc        = i_d.pc;
         reg_d.instr     = BUBBLE_INSTR;
         reg_d.predicted = 1'b0;
         reg_d.valid     = 1'b0;
      end else if (!i_stall) begin
         reg_d = i_d;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         reg_q.pc        <= 32'h0000_0000;
         reg_q.instr     <= BUBBLE_INSTR;
         reg_q.predicted <= 1'b0;
         reg_q.valid     <= 1'b0;
      end else begin
         reg_q <= reg_d;
      end
   end

   assign o_q = reg_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: fetch PC + redirect FSM, feeding the IF/ID register.
// A mispredict that arrives under stall_F is parked in pend_target until fetch frees up.
module fetch_unit
   import pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = pipe_pkg::RESET_PC,
   parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_stall_F,
   input  logic        i_stall_D,
   input  logic        i_flush_D,
   input  logic        i_prediction,
   input  logic [31:0] i_PCTarget_F,
   input  logic        i_mispredict,
   output logic [31:0] o_PC_F,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_PC_D,
   output logic [31:0] o_instr_D,
   output logic [31:0] o_pc_four_D,
   output logic [1:0]  o_index_D,
   output logic        o_predicted_D,
   output logic        o_valid_D,
   output logic [31:0] o_fetch_cnt,
   output logic [31:0] o_redirect_cnt
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  pend_target_q, pend_target_d;
   logic [31:0]  redirect_cnt_q, redirect_cnt_d;
   logic [31:0]  fetch_cnt_q, fetch_cnt_d;
   logic         redirect_inc;
   logic         bubble;
   logic         capture;
   if_id_t       if_id_in;
   if_id_t       if_id_out;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     if (i_mispredict && i_stall_F) state_d = PEND;
         PEND:    if (!i_stall_F) state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   always_comb begin
      pc_d          = pc_q;
      pend_target_d = pend_target_q;
      redirect_inc  = 1'b0;
      case (state_q)
         RUN: begin
            if (i_mispredict && i_stall_F) begin
               pend_target_d = i_PCTarget_F;
            end else if (i_mispredict) begin
               pc_d         = i_PCTarget_F;
               redirect_inc = 1'b1;
            end else if (i_stall_F) begin
               pc_d = pc_q;
            end else if (i_prediction) begin
               pc_d = i_PCTarget_F;
            end else begin
               pc_d = pc_q + 32'd4;
            end
         end
         PEND: begin
            if (i_mispredict) begin
               pend_target_d = i_PCTarget_F;
            end
            // The newest mispredict wins even on the release cycle; prediction is ignored.
            if (!i_stall_F) begin
               pc_d         = i_mispredict ? i_PCTarget_F : pend_target_q;
               redirect_inc = 1'b1;
            end
         end
         default: begin
            pc_d = pc_q;
         end
      endcase

      bubble  = i_flush_D || i_mispredict || (state_q != RUN);
      capture = !bubble && !i_stall_D;

      redirect_cnt_d = redirect_cnt_q + {31'd0, redirect_inc};
      fetch_cnt_d    = fetch_cnt_q + {31'd0, capture};

      if_id_in.pc        = pc_q;
      if_id_in.instr     = i_imem_rdata;
      if_id_in.predicted = i_prediction;
      if_id_in.valid     = 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pc_q           <= RESET_PC;
         pend_target_q  <= 32'h0000_0000;
         redirect_cnt_q <= 32'h0000_0000;
         fetch_cnt_q    <= 32'h0000_0000;
      end else begin
         pc_q           <= pc_d;
         pend_target_q  <= pend_target_d;
         redirect_cnt_q <= redirect_cnt_d;
         fetch_cnt_q    <= fetch_cnt_d;
      end
   end

   if_id_reg #(
      .BUBBLE_INSTR (NOP_INSTR)
   ) u_if_id (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (bubble),
      .i_stall (i_stall_D),
      .i_d     (if_id_in),
      .o_q     (if_id_out)
   );

   assign o_PC_F         = pc_q;
   assign o_PC_D         = if_id_out.pc;
   assign o_instr_D      = if_id_out.instr;
   assign o_predicted_D  = if_id_out.predicted;
   assign o_valid_D      = if_id_out.valid;
   assign o_pc_four_D    = if_id_out.pc + 32'd4;
   assign o_index_D      = if_id_out.pc[3:2];
   assign o_fetch_cnt    = fetch_cnt_q;
   assign o_redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a random run checked
// against a transaction-level model of the fetch/decode rules.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_f, stall_d, flush_d, prediction, mispredict;
   logic [31:0] target;
   logic [31:0] imem_rdata;
   logic [31:0] pc_f, pc_d, instr_d, pc_four_d, fetch_cnt, redirect_cnt;
   logic [1:0]  index_d;
   logic        predicted_d, valid_d;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   // model state
   logic        m_boot;
   logic        m_pend_v;
   logic [31:0] m_pend_t;
   logic [31:0] m_pc, m_pcd, m_instr, m_fc, m_rc;
   logic        m_pred, m_valid;

   always #5 clk = ~clk;

   function automatic logic [31:0] imem_f(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
   endfunction

   assign imem_rdata = imem_f(pc_f);

   fetch_unit dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_stall_F      (stall_f),
      .i_stall_D      (stall_d),
      .i_flush_D      (flush_d),
      .i_prediction   (prediction),
      .i_PCTarget_F   (target),
      .i_mispredict   (mispredict),
      .o_PC_F         (pc_f),
      .i_imem_rdata   (imem_rdata),
      .o_PC_D         (pc_d),
      .o_instr_D      (instr_d),
      .o_pc_four_D    (pc_four_d),
      .o_index_D      (index_d),
      .o_predicted_D  (predicted_d),
      .o_valid_D      (valid_d),
      .o_fetch_cnt    (fetch_cnt),
      .o_redirect_cnt (redirect_cnt)
   );

   task automatic idle_inputs;
      stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
      prediction = 1'b0; mispredict = 1'b0; target = 32'h0;
   endtask

   task automatic model_reset;
      m_boot = 1'b1; m_pend_v = 1'b0; m_pend_t = 32'h0;
      m_pc = 32'h0; m_pcd = 32'h0; m_instr = NOP; m_pred = 1'b0; m_valid = 1'b0;
      m_fc = 32'h0; m_rc = 32'h0;
   endtask

   // Advance one clock and move the model by the same cycle's rules.
   task automatic cycle;
      logic        nb, np;
      logic [31:0] npc, nt, npcd, ninstr, nfc, nrc;
      logic        npred, nvalid;
      logic        kill;
      nb = m_boot; np = m_pend_v; nt = m_pend_t; npc = m_pc;
      npcd = m_pcd; ninstr = m_instr; npred = m_pred; nvalid = m_valid;
      nfc = m_fc; nrc = m_rc;
      kill = flush_d || mispredict || m_boot || m_pend_v;
      if (kill) begin
         npcd = m_pc; ninstr = NOP; npred = 1'b0; nvalid = 1'b0;
      end else if (!stall_d) begin
         npcd = m_pc; ninstr = imem_f(m_pc); npred = prediction; nvalid = 1'b1;
         nfc = m_fc + 1;
      end
      if (m_boot) begin
         nb = 1'b0;
      end else if (m_pend_v) begin
         if (mispredict) nt = target;
         if (!stall_f) begin
            npc = nt; nrc = m_rc + 1; np = 1'b0;
         end
      end else if (mispredict && stall_f) begin
         np = 1'b1; nt = target;
      end else if (mispredict) begin
         npc = target; nrc = m_rc + 1;
      end else if (!stall_f) begin
         npc = prediction ? target : m_pc + 4;
      end
      @(posedge clk);
      #1;
      m_boot = nb; m_pend_v = np; m_pend_t = nt; m_pc = npc;
      m_pcd = npcd; m_instr = ninstr; m_pred = npred; m_valid = nvalid;
      m_fc = nfc; m_rc = nrc;
   endtask

   task automatic test_reset;
      idle_inputs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_checks++; if (pc_f !== 32'h0) begin n_fail++; $display("FAIL reset_pc_f got %h want %h", pc_f, 32'h0); end
      n_checks++; if (pc_d !== 32'h0) begin n_fail++; $display("FAIL reset_pc_d got %h want %h", pc_d, 32'h0); end
      n_checks++; if (instr_d !== NOP) begin n_fail++; $display("FAIL reset_instr got %h want %h", instr_d, NOP); end
      n_checks++; if (predicted_d !== 1'b0) begin n_fail++; $display("FAIL reset_pred got %b want 0", predicted_d); end
      n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_d); end
      n_checks++; if (fetch_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_fetch_cnt got %0d want 0", fetch_cnt); end
      n_checks++; if (redirect_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_cnt got %0d want 0", redirect_cnt); end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_straight_line;
      logic [31:0] exp_pc [4];
      exp_pc[0] = 32'h0; exp_pc[1] = 32'h0; exp_pc[2] = 32'h4; exp_pc[3] = 32'h8;
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         if (i > 0) cycle();
         n_checks++;
         if (pc_f !== exp_pc[i]) begin n_fail++; $display("FAIL straight_pc_c%0d got %h want %h", i + 1, pc_f, exp_pc[i]); end
         if (i == 1) begin
            n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL straight_valid_c2 got %b want 0", valid_d); end
         end
         if (i == 2) begin
            n_checks++; if (valid_d !== 1'b1) begin n_fail++; $display("FAIL straight_valid_c3 got %b want 1", valid_d); end
            n_checks++; if (pc_d !== 32'h0) begin n_fail++; $display("FAIL straight_pc_d got %h want 0", pc_d); end
            n_checks++; if (instr_d !== imem_f(32'h0)) begin n_fail++; $display("FAIL straight_instr got %h want %h", instr_d, imem_f(32'h0)); end
            n_checks++; if (fetch_cnt !== 32'd1) begin n_fail++; $display("FAIL straight_fetch_cnt got %0d want 1", fetch_cnt); end
         end
      end
   endtask

   task automatic test_prediction;
      n_checks++; if (pc_f !== 32'h8) begin n_fail++; $display("FAIL pred_start_pc got %h want 8", pc_f); end
      idle_inputs();
      prediction = 1'b1; target = 32'h40;
      cycle();
      idle_inputs();
      n_checks++; if (pc_f !== 32'h40) begin n_fail++; $display("FAIL pred_pc_f got %h want 40", pc_f); end
      n_checks++; if (predicted_d !== 1'b1) begin n_fail++; $display("FAIL pred_bit got %b want 1", predicted_d); end
      n_checks++; if (pc_d !== 32'h8) begin n_fail++; $display("FAIL pred_pc_d got %h want 8", pc_d); end
      n_checks++; if (pc_four_d !== 32'hC) begin n_fail++; $display("FAIL pred_pc_four got %h want c", pc_four_d); end
      n_checks++; if (index_d !== 2'd2) begin n_fail++; $display("FAIL pred_index got %0d want 2", index_d); end
   endtask

   task automatic test_mispredict;
      idle_inputs();
      prediction = 1'b1; target = 32'h20;
      cycle();
      n_checks++; if (pc_f !== 32'h20) begin n_fail++; $display("FAIL misp_setup_pc got %h want 20", pc_f); end
      prediction = 1'b1; mispredict = 1'b1; target = 32'h100;
      cycle();
      idle_inputs();
      n_checks++; if (pc_f !== 32'h100) begin n_fail++; $display("FAIL misp_pc_f got %h want 100", pc_f); end
      n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL misp_valid got %b want 0", valid_d); end
      n_checks++; if (instr_d !== NOP) begin n_fail++; $display("FAIL misp_instr got %h want %h", instr_d, NOP); end
      n_checks++; if (redirect_cnt !== 32'd1) begin n_fail++; $display("FAIL misp_redirect_cnt got %0d want 1", redirect_cnt); end
   endtask

   task automatic test_pend_redirect;
      logic [31:0] held;
      held = pc_f;
      for (int k = 0; k < 3; k++) begin
         idle_inputs();
         stall_f = 1'b1; stall_d = 1'b1;
         if (k == 0) begin mispredict = 1'b1; prediction = 1'b1; target = 32'h200; end
         cycle();
         n_checks++;
         if (pc_f !== held) begin n_fail++; $display("FAIL pend_hold_%0d got %h want %h", k, pc_f, held); end
      end
      idle_inputs();
      prediction = 1'b1; target = 32'h300;
      cycle();
      idle_inputs();
      n_checks++; if (pc_f !== 32'h200) begin n_fail++; $display("FAIL pend_release_pc got %h want 200", pc_f); end
      n_checks++; if (redirect_cnt !== 32'd2) begin n_fail++; $display("FAIL pend_redirect_cnt got %0d want 2", redirect_cnt); end
      n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL pend_valid got %b want 0", valid_d); end
      cycle();
      n_checks++; if (pc_f !== 32'h204) begin n_fail++; $display("FAIL pend_after_pc got %h want 204", pc_f); end
      n_checks++; if (redirect_cnt !== 32'd2) begin n_fail++; $display("FAIL pend_once got %0d want 2", redirect_cnt); end
   endtask

   task automatic test_stall_flush;
      logic [31:0] held_instr, held_cnt, pc_now;
      idle_inputs();
      cycle();
      n_checks++; if (valid_d !== 1'b1) begin n_fail++; $display("FAIL sf_capture_valid got %b want 1", valid_d); end
      held_instr = instr_d; held_cnt = fetch_cnt;
      stall_f = 1'b1; stall_d = 1'b1;
      cycle();
      n_checks++; if (instr_d !== held_instr) begin n_fail++; $display("FAIL sf_hold_instr got %h want %h", instr_d, held_instr); end
      n_checks++; if (valid_d !== 1'b1) begin n_fail++; $display("FAIL sf_hold_valid got %b want 1", valid_d); end
      n_checks++; if (fetch_cnt !== held_cnt) begin n_fail++; $display("FAIL sf_hold_cnt got %0d want %0d", fetch_cnt, held_cnt); end
      pc_now = pc_f;
      flush_d = 1'b1;
      cycle();
      idle_inputs();
      n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL sf_flush_valid got %b want 0", valid_d); end
      n_checks++; if (instr_d !== NOP) begin n_fail++; $display("FAIL sf_flush_instr got %h want %h", instr_d, NOP); end
      n_checks++; if (pc_d !== pc_now) begin n_fail++; $display("FAIL sf_flush_pc_d got %h want %h", pc_d, pc_now); end
   endtask

   task automatic test_reset_in_pend;
      idle_inputs();
      stall_f = 1'b1; stall_d = 1'b1; mispredict = 1'b1; prediction = 1'b1; target = 32'h200;
      cycle();
      mispredict = 1'b0; prediction = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      n_checks++; if (pc_f !== 32'h0) begin n_fail++; $display("FAIL rst_pend_async_pc got %h want 0", pc_f); end
      n_checks++; if (redirect_cnt !== 32'h0) begin n_fail++; $display("FAIL rst_pend_cnt got %0d want 0", redirect_cnt); end
      @(posedge clk);
      #1;
      idle_inputs();
      rst = 1'b0;
      model_reset();
      for (int k = 0; k < 8; k++) begin
         cycle();
         n_checks++;
         if (pc_f !== m_pc || pc_f === 32'h200) begin n_fail++; $display("FAIL rst_pend_stale_%0d got %h want %h", k, pc_f, m_pc); end
      end
      n_checks++; if (redirect_cnt !== 32'h0) begin n_fail++; $display("FAIL rst_pend_no_redirect got %0d want 0", redirect_cnt); end
   endtask

   task automatic test_random;
      for (int i = 0; i < 400; i++) begin
         idle_inputs();
         stall_f = ($urandom_range(0, 3) == 0);
         stall_d = stall_f || ($urandom_range(0, 5) == 0);
         flush_d = ($urandom_range(0, 9) == 0);
         prediction = ($urandom_range(0, 3) == 0);
         target = {$urandom_range(0, 16'hFFFF), 16'h0} | {16'h0, 14'($urandom_range(0, 16'h3FFF)), 2'b00};
         mispredict = ($urandom_range(0, 9) == 0) && (!m_pend_v || stall_f);
         if (mispredict) prediction = 1'b1;
         cycle();
         n_checks++; if (pc_f !== m_pc) begin n_fail++; $display("FAIL rnd_pc_f[%0d] got %h want %h", i, pc_f, m_pc); end
         n_checks++; if (pc_d !== m_pcd) begin n_fail++; $display("FAIL rnd_pc_d[%0d] got %h want %h", i, pc_d, m_pcd); end
         n_checks++; if (instr_d !== m_instr) begin n_fail++; $display("FAIL rnd_instr[%0d] got %h want %h", i, instr_d, m_instr); end
         n_checks++; if (predicted_d !== m_pred) begin n_fail++; $display("FAIL rnd_pred[%0d] got %b want %b", i, predicted_d, m_pred); end
         n_checks++; if (valid_d !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b want %b", i, valid_d, m_valid); end
         n_checks++; if (pc_four_d !== m_pcd + 32'd4) begin n_fail++; $display("FAIL rnd_pc_four[%0d] got %h want %h", i, pc_four_d, m_pcd + 32'd4); end
         n_checks++; if (index_d !== m_pcd[3:2]) begin n_fail++; $display("FAIL rnd_index[%0d] got %0d want %0d", i, index_d, m_pcd[3:2]); end
         n_checks++; if (fetch_cnt !== m_fc) begin n_fail++; $display("FAIL rnd_fetch_cnt[%0d] got %0d want %0d", i, fetch_cnt, m_fc); end
         n_checks++; if (redirect_cnt !== m_rc) begin n_fail++; $display("FAIL rnd_redirect_cnt[%0d] got %0d want %0d", i, redirect_cnt, m_rc); end
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      model_reset();
      #2;
      test_reset();
      test_straight_line();
      test_prediction();
      test_mispredict();
      test_pend_redirect();
      test_stall_flush();
      test_reset_in_pend();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
